// File: rtl/uart_tx_buffer_if.sv
// Processor write port and transmitter launch/done handshake for uart_tx_buffer.
// UART_TXBUF_OVF_EN adds the ovf_clr/ovf sticky overflow pair.
interface uart_tx_buffer_if #(
  parameter int AW = 4
);
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        full;
  logic        empty;
  logic [AW:0] level;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        tx_done;
  logic        busy;
`ifdef UART_TXBUF_OVF_EN
  logic        ovf_clr;
  logic        ovf;

  modport slave (
    input  wr_data, wr_en, tx_done, ovf_clr,
    output full, empty, level, tx_data, tx_en, busy, ovf
  );
  modport master (
    output wr_data, wr_en, tx_done, ovf_clr,
    input  full, empty, level, tx_data, tx_en, busy, ovf
  );
`else
  modport slave (
    input  wr_data, wr_en, tx_done,
    output full, empty, level, tx_data, tx_en, busy
  );
  modport master (
    output wr_data, wr_en, tx_done,
    input  full, empty, level, tx_data, tx_en, busy
  );
`endif
endinterface

// File: rtl/uart_tx_buffer.sv
// Byte FIFO feeding a UART transmitter one byte per TxDone.
// Define UART_TXBUF_OVF_EN to add a sticky overflow flag with clear.
module uart_tx_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input logic             clk,
  input logic             rst,
  uart_tx_buffer_if.slave bus
);

  // state  | meaning
  // S_IDLE | no byte in flight; pops as soon as the FIFO is non-empty
  // S_WAIT | byte launched; waiting for tx_done from the transmitter
  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state;
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wp;
  logic [AW:0] rp;
  logic [AW:0] level;
  logic        full;
  logic        empty;
  logic        push;
  logic [7:0]  tx_data;
  logic        tx_en;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign level = wp - rp;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign push  = bus.wr_en && !full;

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= bus.wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wp <= '0;
    else if (push) wp <= wp + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      rp      <= '0;
      tx_en   <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      tx_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!empty) begin
            tx_data <= mem[rp[AW-1:0]];
            rp      <= rp + 1'b1;
            tx_en   <= 1'b1;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          // tx_done is not trusted in the launch cycle itself
          if (bus.tx_done && !tx_en) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.full    = full;
  assign bus.empty   = empty;
  assign bus.level   = level;
  assign bus.tx_data = tx_data;
  assign bus.tx_en   = tx_en;
  assign bus.busy    = (state == S_WAIT);

`ifdef UART_TXBUF_OVF_EN
  logic ovf;

  // Set has priority over clear so a drop in the clear cycle is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf <= 1'b0;
    else if (bus.wr_en && full) ovf <= 1'b1;
    else if (bus.ovf_clr) ovf <= 1'b0;
  end

  assign bus.ovf = ovf;
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer (DEPTH=4) with a mock transmitter
// that returns tx_done 20 cycles after each tx_en.
module tb_uart_tx_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  uart_tx_buffer_if #(.AW(AW)) bus();

  uart_tx_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit hold     = 1'b0;
  int pulse_err = 0;
  logic [7:0] rxq[$];
  int lq[$];
  int dq[$];

  initial forever @(posedge clk) cyc++;

  // Mock transmitter: logs each launch, answers with a one-cycle tx_done.
  initial begin
    int cnt;
    bit pending;
    bit prev_en;
    cnt = 0;
    pending = 1'b0;
    prev_en = 1'b0;
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      bus.tx_done = 1'b0;
      if (rst) begin
        pending = 1'b0;
        prev_en = 1'b0;
      end else if (bus.tx_en) begin
        if (prev_en) pulse_err++;
        rxq.push_back(bus.tx_data);
        lq.push_back(cyc);
        pending = 1'b1;
        cnt = 19;
        prev_en = 1'b1;
      end else begin
        prev_en = 1'b0;
        if (pending) begin
          if (cnt > 1) cnt--;
          else if (!hold) begin
            bus.tx_done = 1'b1;
            pending = 1'b0;
            dq.push_back(cyc + 1);
          end
        end
      end
    end
  end

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.full !== 1'b0) $display("FAIL reset_full got=%b exp=0", bus.full); else n_pass++;
    n_checks++; if (bus.empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", bus.empty); else n_pass++;
    n_checks++; if (bus.level !== 3'd0) $display("FAIL reset_level got=%0d exp=0", bus.level); else n_pass++;
    n_checks++; if (bus.tx_data !== 8'h00) $display("FAIL reset_tx_data got=%h exp=00", bus.tx_data); else n_pass++;
    n_checks++; if (bus.tx_en !== 1'b0) $display("FAIL reset_tx_en got=%b exp=0", bus.tx_en); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else n_pass++;
`ifdef UART_TXBUF_OVF_EN
    n_checks++; if (bus.ovf !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", bus.ovf); else n_pass++;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.level !== 3'd0) $display("FAIL reset_release_level got=%0d exp=0", bus.level); else n_pass++;
  endtask

  task automatic test_single();
    int base;
    int ln;
    base = rxq.size();
    @(negedge clk);
    bus.wr_data = 8'h53;
    bus.wr_en = 1'b1;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    n_checks++; if (bus.empty !== 1'b0) $display("FAIL single_wr_empty got=%b exp=0", bus.empty); else n_pass++;
    n_checks++; if (bus.level !== 3'd1) $display("FAIL single_wr_level got=%0d exp=1", bus.level); else n_pass++;
    n_checks++; if (bus.tx_en !== 1'b0) $display("FAIL single_no_bypass got=%b exp=0", bus.tx_en); else n_pass++;
    @(posedge clk); #1;
    ln = cyc;
    n_checks++; if (bus.tx_en !== 1'b1) $display("FAIL single_launch_en got=%b exp=1", bus.tx_en); else n_pass++;
    n_checks++; if (bus.tx_data !== 8'h53) $display("FAIL single_launch_data got=%h exp=53", bus.tx_data); else n_pass++;
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL single_busy got=%b exp=1", bus.busy); else n_pass++;
    n_checks++; if (bus.level !== 3'd0) $display("FAIL single_pop_level got=%0d exp=0", bus.level); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (bus.tx_en !== 1'b0) $display("FAIL single_en_width got=%b exp=0", bus.tx_en); else n_pass++;
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL single_busy_hold got=%b exp=1", bus.busy); else n_pass++;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL single_done_timeout busy=%b exp=0", bus.busy); else n_pass++;
    n_checks++; if (cyc - ln !== 20) $display("FAIL single_busy_len got=%0d exp=20", cyc - ln); else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++; if (rxq.size() - base !== 1) $display("FAIL single_pulse_count got=%0d exp=1", rxq.size() - base); else n_pass++;
    n_checks++; if (rxq[base] !== 8'h53) $display("FAIL single_rx got=%h exp=53", rxq[base]); else n_pass++;
    n_checks++; if (bus.tx_data !== 8'h53) $display("FAIL single_data_hold got=%h exp=53", bus.tx_data); else n_pass++;
  endtask

  task automatic test_burst();
    int base, lbase, dbase;
    logic [2:0] peak;
    base = rxq.size();
    lbase = lq.size();
    dbase = dq.size();
    peak = 3'd0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.wr_data = 8'(8'h54 + i);
      bus.wr_en = 1'b1;
      @(negedge clk);
      if (bus.level > peak) peak = bus.level;
    end
    bus.wr_en = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.level > peak) peak = bus.level;
      if (lq.size() - lbase >= 4 && !bus.busy) break;
    end
    n_checks++; if (lq.size() - lbase !== 4) $display("FAIL burst_count got=%0d exp=4", lq.size() - lbase); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (rxq[base+i] !== 8'(8'h54 + i)) $display("FAIL burst_rx%0d got=%h exp=%h", i, rxq[base+i], 8'(8'h54 + i)); else n_pass++;
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (lq[lbase+i+1] - dq[dbase+i] !== 1) $display("FAIL burst_gap%0d got=%0d exp=1", i, lq[lbase+i+1] - dq[dbase+i]); else n_pass++;
    end
    n_checks++; if (peak !== 3'd3) $display("FAIL burst_peak_level got=%0d exp=3", peak); else n_pass++;
    n_checks++; if (bus.empty !== 1'b1) $display("FAIL burst_empty got=%b exp=1", bus.empty); else n_pass++;
  endtask

  task automatic test_overflow();
    int base, lbase;
    base = rxq.size();
    lbase = lq.size();
    hold = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      bus.wr_data = 8'(8'h60 + i);
      bus.wr_en = 1'b1;
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    n_checks++; if (bus.full !== 1'b1) $display("FAIL ovf_full got=%b exp=1", bus.full); else n_pass++;
    n_checks++; if (bus.level !== 3'd4) $display("FAIL ovf_level got=%0d exp=4", bus.level); else n_pass++;
    n_checks++; if (rxq.size() - base !== 1) $display("FAIL ovf_first_pop got=%0d exp=1", rxq.size() - base); else n_pass++;
`ifdef UART_TXBUF_OVF_EN
    n_checks++; if (bus.ovf !== 1'b1) $display("FAIL ovf_set got=%b exp=1", bus.ovf); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.ovf !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", bus.ovf); else n_pass++;
    bus.wr_data = 8'h66;
    bus.wr_en = 1'b1;
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.ovf_clr = 1'b0;
    n_checks++; if (bus.ovf !== 1'b1) $display("FAIL ovf_set_wins got=%b exp=1", bus.ovf); else n_pass++;
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    n_checks++; if (bus.ovf !== 1'b0) $display("FAIL ovf_clear got=%b exp=0", bus.ovf); else n_pass++;
`endif
    hold = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (lq.size() - lbase >= 5 && !bus.busy && bus.empty) break;
    end
    n_checks++; if (lq.size() - lbase !== 5) $display("FAIL ovf_drain_count got=%0d exp=5", lq.size() - lbase); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (rxq[base+i] !== 8'(8'h60 + i)) $display("FAIL ovf_rx%0d got=%h exp=%h", i, rxq[base+i], 8'(8'h60 + i)); else n_pass++;
    end
  endtask

  task automatic test_simul();
    int base, lbase;
    base = rxq.size();
    lbase = lq.size();
    @(negedge clk);
    bus.wr_data = 8'hA1;
    bus.wr_en = 1'b1;
    @(negedge clk);
    bus.wr_data = 8'hB2;
    @(negedge clk);
    bus.wr_en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (lq.size() > lbase && cyc == lq[lbase] + 20) break;
      @(negedge clk);
    end
    n_checks++; if (bus.level !== 3'd1) $display("FAIL simul_pre_level got=%0d exp=1", bus.level); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL simul_pre_idle got=%b exp=0", bus.busy); else n_pass++;
    bus.wr_data = 8'hC3;
    bus.wr_en = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0;
    n_checks++; if (bus.level !== 3'd1) $display("FAIL simul_level got=%0d exp=1", bus.level); else n_pass++;
    n_checks++; if (bus.tx_en !== 1'b1) $display("FAIL simul_launch got=%b exp=1", bus.tx_en); else n_pass++;
    n_checks++; if (bus.tx_data !== 8'hB2) $display("FAIL simul_data got=%h exp=b2", bus.tx_data); else n_pass++;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (lq.size() - lbase >= 3 && !bus.busy && bus.empty) break;
    end
    n_checks++; if (lq.size() - lbase !== 3) $display("FAIL simul_count got=%0d exp=3", lq.size() - lbase); else n_pass++;
    n_checks++; if (rxq[base+2] !== 8'hC3) $display("FAIL simul_rx_last got=%h exp=c3", rxq[base+2]); else n_pass++;
  endtask

  task automatic test_wrap();
    int base, lbase, nxt;
    base = rxq.size();
    lbase = lq.size();
    nxt = 0;
    @(negedge clk);
    for (int i = 0; i < 1500; i++) begin
      if (nxt < 20 && !bus.full) begin
        bus.wr_data = 8'(nxt);
        bus.wr_en = 1'b1;
        nxt++;
      end else begin
        bus.wr_en = 1'b0;
      end
      @(negedge clk);
      if (nxt == 20 && lq.size() - lbase >= 20 && !bus.busy) break;
    end
    bus.wr_en = 1'b0;
    n_checks++; if (lq.size() - lbase !== 20) $display("FAIL wrap_count got=%0d exp=20", lq.size() - lbase); else n_pass++;
    for (int i = 0; i < 20; i++) begin
      n_checks++; if (rxq[base+i] !== 8'(i)) $display("FAIL wrap_rx%0d got=%h exp=%h", i, rxq[base+i], 8'(i)); else n_pass++;
    end
    n_checks++; if (bus.level !== 3'd0) $display("FAIL wrap_level got=%0d exp=0", bus.level); else n_pass++;
    n_checks++; if (pulse_err !== 0) $display("FAIL tx_en_width got=%0d long pulses exp=0", pulse_err); else n_pass++;
  endtask

  task automatic test_midreset();
    int lbase;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.wr_data = 8'(8'h71 + i);
      bus.wr_en = 1'b1;
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL midrst_pre_busy got=%b exp=1", bus.busy); else n_pass++;
    n_checks++; if (bus.level !== 3'd2) $display("FAIL midrst_pre_level got=%0d exp=2", bus.level); else n_pass++;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.level !== 3'd0) $display("FAIL midrst_level got=%0d exp=0", bus.level); else n_pass++;
    n_checks++; if (bus.empty !== 1'b1) $display("FAIL midrst_empty got=%b exp=1", bus.empty); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", bus.busy); else n_pass++;
    n_checks++; if (bus.tx_data !== 8'h00) $display("FAIL midrst_tx_data got=%h exp=00", bus.tx_data); else n_pass++;
    n_checks++; if (bus.tx_en !== 1'b0) $display("FAIL midrst_tx_en got=%b exp=0", bus.tx_en); else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lbase = lq.size();
    repeat (3) @(negedge clk);
    n_checks++; if (bus.level !== 3'd0) $display("FAIL midrst_release_level got=%0d exp=0", bus.level); else n_pass++;
    n_checks++; if (lq.size() !== lbase) $display("FAIL midrst_no_launch got=%0d exp=%0d", lq.size(), lbase); else n_pass++;
  endtask

  initial begin
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
`ifdef UART_TXBUF_OVF_EN
    bus.ovf_clr = 1'b0;
`endif
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_simul();
    test_wrap();
    test_midreset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffer.md
# uart_tx_buffer

Byte FIFO and launch sequencer sitting directly upstream of the UART transmitter. It accepts bytes from the processor-side write port at full clock rate, stores up to DEPTH of them, and feeds them one at a time to the transmitter's TxData/TxEn inputs. It launches the next byte only after the transmitter reports TxDone, so software never has to poll the serial line.

## Interface
- DEPTH, 16, FIFO entries; power of two, ≥2
- AW, 4, pointer width; log2(DEPTH)

Ports:
- Clk  in  1  system clock; all logic on rising edge
- Rst  in  1  asynchronous, active-high reset
- WrData  in  8  byte to enqueue
- WrEn  in  1  enqueue strobe; sampled each rising edge
- Full  out  1  FIFO holds DEPTH entries (registered)
- Empty  out  1  FIFO holds 0 entries (registered)
- Level  out  AW+1  current entry count, 0..DEPTH
- TxData  out  8  byte presented to the transmitter; registered
- TxEn  out  1  one-cycle launch pulse to the transmitter
- TxDone  in  1  one-cycle pulse from the transmitter at end of stop bit
- Busy  out  1  high while a byte is in flight (TxEn issued, TxDone not yet seen)

## Operation
- Storage: DEPTH×8 array, write pointer wp, read pointer rp, both AW+1 bits wide (extra wrap bit). Level = wp − rp modulo 2^(AW+1). Full = (Level == DEPTH). Empty = (Level == 0).
- Write: on an edge with WrEn=1 and Full=0, mem[wp[AW-1:0]] ← WrData and wp increments. WrEn with Full=1 drops the byte, with no state change.
- Sequencer FSM, two states:
  - IDLE: when Empty=0, at the next edge load TxData ← mem[rp], increment rp, set TxEn=1, go to WAIT.
  - WAIT: TxEn returns to 0 after one cycle. Stay in WAIT until TxDone is sampled high, then go to IDLE. TxDone is ignored during the cycle TxEn is high.
- TxDone in IDLE is ignored.
- Busy = (state == WAIT).
- Simultaneous write and pop in one edge: both take effect and Level is unchanged. Full and Empty are evaluated from the pre-edge count, so a write while Full is dropped even if a pop occurs at the same edge.
- There is no bypass path. A byte written into an empty FIFO is always stored first and then popped.
- Pointers wrap naturally at 2^(AW+1). DEPTH consecutive writes followed by DEPTH pops return the pointers to equal values.
- Reset (asynchronous, at any time, including mid-byte): wp=rp=0, state=IDLE, TxEn=0, TxData=8'h00. FIFO contents are not cleared. Any byte already launched is abandoned; the transmitter handles its own reset.

## Timing
- Reset values: Full=0, Empty=1, Level=0, TxData=8'h00, TxEn=0, Busy=0.
- Write latency: WrEn at edge N gives Empty=0 and Level=1 after edge N.
- Launch latency, FIFO previously empty and FSM in IDLE:
  - WrEn at edge N.
  - At edge N+1, TxData is loaded and TxEn=1.
  - TxEn is high for exactly one cycle (edge N+1 to N+2).
- Back-to-back: TxDone sampled at edge M gives IDLE after M. If the FIFO is not empty, the next TxEn rises at edge M+1. The minimum gap is 1 idle cycle between TxDone and the next TxEn.
- TxData is stable from its load edge until the next launch; it holds the last byte when idle.
- Throughput is bounded by the transmitter. At 5208 clocks/bit (9600 baud, 50 MHz), a frame is ≈52080 cycles.

## Configuration
- Macro: UART_TXBUF_OVF_EN.
- Defined:
  - Adds input OvfClr (1 bit) and output Ovf (1 bit, reset 0).
  - Ovf sets on any edge with WrEn=1 and Full=1, and stays set (sticky) until OvfClr=1 is sampled.
  - If set and clear occur at the same edge, set wins.
- Undefined: both ports and the flag logic are absent; dropped writes are silent.

## Test plan
All scenarios use DEPTH=4 and a mock transmitter that pulses TxDone 20 cycles after each TxEn.
- **Reset:** assert Rst mid-sim → all outputs take their reset values within the same cycle, asynchronously; Level=0 after release.
- **Single byte:** write 8'h53 at edge N → TxData=8'h53 and TxEn=1 for exactly cycle N+1; Busy stays high until TxDone; exactly one TxEn pulse is issued.
- **Burst:** write 8'h54, 8'h55, 8'h56, 8'h57 on consecutive edges → launches occur in that order, each TxEn exactly 1 cycle after the previous TxDone; Level peaks at 3 (one byte is already popped); Empty=1 after the last pop.
- **Overflow:** hold the transmitter (no TxDone), then write 6 bytes → after the first pop the FIFO fills to 4; the 6th byte is dropped and Full=1. With UART_TXBUF_OVF_EN, Ovf=1 until OvfClr is pulsed.
- **Simultaneous write/pop at Level=1:** Level stays 1; the new byte is transmitted next; no byte is lost or duplicated.
- **Wrap-around:** send 20 bytes (8'h00..8'h13) through → the received sequence matches in order, and pointers pass the wrap boundary at least 4 times.
